// File: rtl/comparator_arbiter.sv
// Round-robin arbiter that time-shares one unsigned magnitude comparator among
// NREQ requesters and returns tagged gt/eq/lt results on a valid/ready channel.
module comparator_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_flat,
    input  logic [NREQ*W-1:0] b_flat,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_gt,
    output logic              rsp_eq,
    output logic              rsp_lt,
    output logic [1:0]        dbg_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    // Response channel: a response is transferred on a rising edge where
    // rsp_valid && rsp_ready; rsp_* hold stable while rsp_valid && !rsp_ready.
    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   w_winner;
    logic            w_found;
    logic [NREQ-1:0] w_gnt;
    logic [W-1:0]    r_op_a;
    logic [W-1:0]    r_op_b;
    logic [IDW-1:0]  r_op_id;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic            r_rsp_gt;
    logic            r_rsp_eq;
    logic            r_rsp_lt;

    // Scan starting at r_rr_ptr with wrap-around; first set request wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_found  = 1'b1;
                w_winner = PW'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (rst_n && (r_state == ST_IDLE) && w_found) begin
            w_gnt[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_found)   w_state_nxt = ST_CMP;
            ST_CMP:                 w_state_nxt = ST_RSP;
            ST_RSP:  if (rsp_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_id     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_gt    <= 1'b0;
            r_rsp_eq    <= 1'b0;
            r_rsp_lt    <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // Operands are captured only here, so later input changes cannot disturb the compare.
                    if (w_found) begin
                        r_op_a   <= a_flat[int'(w_winner)*W +: W];
                        r_op_b   <= b_flat[int'(w_winner)*W +: W];
                        r_op_id  <= IDW'(w_winner);
                        r_rr_ptr <= PW'((int'(w_winner) + 1) % NREQ);
                    end
                end
                ST_CMP: begin
                    r_rsp_gt    <= (r_op_a > r_op_b);
                    r_rsp_eq    <= (r_op_a == r_op_b);
                    r_rsp_lt    <= (r_op_a < r_op_b);
                    r_rsp_id    <= r_op_id;
                    r_rsp_valid <= 1'b1;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = w_gnt;
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_gt    = r_rsp_gt;
    assign rsp_eq    = r_rsp_eq;
    assign rsp_lt    = r_rsp_lt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_comparator_arbiter.sv
// Directed bench for comparator_arbiter: grant order, latency, backpressure,
// wrap-around, reset abort and operand capture, with hand-computed expectations.
module tb_comparator_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_flat;
    logic [NREQ*W-1:0] b_flat;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_gt;
    logic              rsp_eq;
    logic              rsp_lt;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Expected responses, packed as {id[1:0], gt, eq, lt}.
    logic [4:0] exp_q[$];

    comparator_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_gt    (rsp_gt),
        .rsp_eq    (rsp_eq),
        .rsp_lt    (rsp_lt),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_ab(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        a_flat[idx*W +: W] = a;
        b_flat[idx*W +: W] = b;
    endtask

    function automatic logic [2:0] flags();
        return {rsp_gt, rsp_eq, rsp_lt};
    endfunction

    // Called at a falling edge in IDLE with inputs driven and rsp_ready=1.
    // Walks grant (T), compare (T+1), response (T+2), back to IDLE (T+3).
    task automatic run_txn(input int exp_id, input logic [2:0] exp_flags);
        logic [4:0] e;
        #1;
        check_eq("grant", 32'(gnt), 32'(1 << exp_id));
        check_eq("idle_busy", 32'(busy), 32'd0);
        exp_q.push_back({2'(exp_id), exp_flags});
        @(negedge clk);
        #1;
        check_eq("cmp_gnt", 32'(gnt), 32'd0);
        check_eq("cmp_busy", 32'(busy), 32'd1);
        check_eq("cmp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("rsp_gnt", 32'(gnt), 32'd0);
        e = exp_q.pop_front();
        check_eq("rsp_id", 32'(rsp_id), 32'(e[4:3]));
        check_eq("rsp_flags", 32'(flags()), 32'(e[2:0]));
        @(negedge clk);
        #1;
        check_eq("back_idle", 32'(dbg_state), 32'd0);
        check_eq("accept_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        a_flat    = '0;
        b_flat    = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        req = 4'hF;
        #1;
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_id", 32'(rsp_id), 32'd0);
        check_eq("rst_flags", 32'(flags()), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // single requester 0: 1 < 2
        @(negedge clk);
        set_ab(0, 4'd1, 4'd2);
        req = 4'b0001;
        rsp_ready = 1'b1;
        run_txn(0, 3'b001);
        req = '0;
        #1;
        check_eq("t1_idle_gnt", 32'(gnt), 32'd0);

        // all requesting, round-robin 0,1,2,3,0 every 3 cycles
        reset_dut();
        for (int i = 0; i < NREQ; i++) set_ab(i, 4'd5, 4'd4);
        req = 4'hF;
        for (int i = 0; i < 5; i++) run_txn(i % NREQ, 3'b100);
        req = '0;

        // backpressure on requester 2 (7 == 7)
        reset_dut();
        set_ab(2, 4'd7, 4'd7);
        req = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        check_eq("t3_gnt", 32'(gnt), 32'b0100);
        @(negedge clk);
        req = '0;
        #1;
        check_eq("t3_cmp_busy", 32'(busy), 32'd1);
        @(negedge clk);
        // new requests during RSP must wait
        req = 4'b1001;
        set_ab(3, 4'd15, 4'd10);
        set_ab(0, 4'd3, 4'd9);
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("t3_hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("t3_hold_flags", 32'(flags()), 32'b010);
            check_eq("t3_hold_id", 32'(rsp_id), 32'd2);
            check_eq("t3_hold_busy", 32'(busy), 32'd1);
            check_eq("t3_hold_gnt", 32'(gnt), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check_eq("t3_idle", 32'(dbg_state), 32'd0);
        check_eq("t3_valid_low", 32'(rsp_valid), 32'd0);
        check_eq("t3_flags_kept", 32'(flags()), 32'b010);

        // wrap: pointer at 3, req=1001 -> 3 then 0
        run_txn(3, 3'b100);
        run_txn(0, 3'b001);

        // reset during CMP of a (0,0) compare on requester 1
        req = 4'b0010;
        set_ab(1, 4'd0, 4'd0);
        #1;
        check_eq("t5_gnt", 32'(gnt), 32'b0010);
        @(negedge clk);
        #1;
        check_eq("t5_in_cmp", 32'(dbg_state), 32'd1);
        rst_n = 1'b0;
        req = 4'hF;
        #1;
        check_eq("t5_rst_gnt", 32'(gnt), 32'd0);
        check_eq("t5_rst_busy", 32'(busy), 32'd0);
        check_eq("t5_rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("t5_rst_flags", 32'(flags()), 32'd0);
        check_eq("t5_rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        #1;
        check_eq("t5_rst_valid2", 32'(rsp_valid), 32'd0);
        check_eq("t5_rst_gnt2", 32'(gnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_ab(0, 4'd0, 4'd8);
        #1;
        check_eq("t5_restart_gnt", 32'(gnt), 32'b0001);
        check_eq("t5_no_valid", 32'(rsp_valid), 32'd0);

        // operand a0 changes 0 -> 15 after the grant; captured 0 < 8
        @(negedge clk);
        set_ab(0, 4'd15, 4'd8);
        req = '0;
        #1;
        check_eq("t6_cmp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check_eq("t6_valid", 32'(rsp_valid), 32'd1);
        check_eq("t6_id", 32'(rsp_id), 32'd0);
        check_eq("t6_flags", 32'(flags()), 32'b001);
        @(negedge clk);
        #1;
        check_eq("t6_done", 32'(rsp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
